// File: rtl/alu_control_if.sv
// Decode-side bundle between the main decoder and the ALU operation decoder.
// The master drives the instruction fields; the slave returns the registered
// ALU operation code and the illegal-encoding flag.
interface alu_control_if;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_control;
  logic       illegal;

  modport master (
    output alu_op,
    output funct3,
    output funct7,
    input  alu_control,
    input  illegal
  );

  modport slave (
    input  alu_op,
    input  funct3,
    input  funct7,
    output alu_control,
    output illegal
  );
endinterface

// File: rtl/alu_control.sv
// Registered RV32I ALU-operation decoder. Maps the main-decoder ALU class and
// funct3/funct7 to a 4-bit ALU op code, flagging encodings that have no RV32I
// ALU meaning. Outputs are valid one clock after the inputs.
module alu_control (
  input  logic          clk,
  input  logic          reset,
  alu_control_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [3:0] next_ctl;
  logic       next_ill;

  // Combinational decode; every path lands on a defined value so no latch forms
  // and unknown inputs fall back to ADD with the illegal flag raised.
  always_comb begin
    next_ctl = OP_ADD;
    next_ill = 1'b1;
    case (bus.alu_op)
      2'b00: begin
        next_ctl = OP_ADD;
        next_ill = 1'b0;
      end
      2'b01: begin
        next_ill = 1'b0;
        case (bus.funct3)
          3'b000, 3'b001: next_ctl = OP_SUB;
          3'b100, 3'b101: next_ctl = OP_SLT;
          3'b110, 3'b111: next_ctl = OP_SLTU;
          3'b010, 3'b011: begin
            next_ctl = OP_SUB;
            next_ill = 1'b1;
          end
          default: begin
            next_ctl = OP_ADD;
            next_ill = 1'b1;
          end
        endcase
      end
      2'b10: begin
        if (bus.funct7 == F7_BASE) begin
          next_ill = 1'b0;
          case (bus.funct3)
            3'b000: next_ctl = OP_ADD;
            3'b001: next_ctl = OP_SLL;
            3'b010: next_ctl = OP_SLT;
            3'b011: next_ctl = OP_SLTU;
            3'b100: next_ctl = OP_XOR;
            3'b101: next_ctl = OP_SRL;
            3'b110: next_ctl = OP_OR;
            3'b111: next_ctl = OP_AND;
            default: begin
              next_ctl = OP_ADD;
              next_ill = 1'b1;
            end
          endcase
        end else if (bus.funct7 == F7_ALT) begin
          case (bus.funct3)
            3'b000: begin
              next_ctl = OP_SUB;
              next_ill = 1'b0;
            end
            3'b101: begin
              next_ctl = OP_SRA;
              next_ill = 1'b0;
            end
            default: begin
              next_ctl = OP_ADD;
              next_ill = 1'b1;
            end
          endcase
        end else begin
          next_ctl = OP_ADD;
          next_ill = 1'b1;
        end
      end
      2'b11: begin
        next_ill = 1'b0;
        case (bus.funct3)
          3'b000: next_ctl = OP_ADD;
          3'b010: next_ctl = OP_SLT;
          3'b011: next_ctl = OP_SLTU;
          3'b100: next_ctl = OP_XOR;
          3'b110: next_ctl = OP_OR;
          3'b111: next_ctl = OP_AND;
          // Shift-immediates: funct7 is a real opcode field here, not immediate bits.
          3'b001: begin
            next_ctl = OP_SLL;
            next_ill = (bus.funct7 != F7_BASE);
          end
          3'b101: begin
            if (bus.funct7 == F7_ALT) begin
              next_ctl = OP_SRA;
            end else begin
              next_ctl = OP_SRL;
              next_ill = (bus.funct7 != F7_BASE);
            end
          end
          default: begin
            next_ctl = OP_ADD;
            next_ill = 1'b1;
          end
        endcase
      end
      default: begin
        next_ctl = OP_ADD;
        next_ill = 1'b1;
      end
    endcase
  end

  // Output registers: load every edge, clear to ADD/legal on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.alu_control <= OP_ADD;
      bus.illegal     <= 1'b0;
    end else begin
      bus.alu_control <= next_ctl;
      bus.illegal     <= next_ill;
    end
  end

endmodule

// File: tb/tb_alu_control.sv
// Directed bench for the registered ALU-operation decoder.
module tb_alu_control;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  alu_control_if bus ();

  alu_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare registered outputs against hand-computed values.
  task automatic check(input string tag, input logic [3:0] exp_ctl, input logic exp_ill);
    vectors++;
    assert ({bus.alu_control, bus.illegal} === {exp_ctl, exp_ill})
    else begin
      miscompares++;
      $error("FAIL %s: observed ctl=%b ill=%b expected ctl=%b ill=%b",
             tag, bus.alu_control, bus.illegal, exp_ctl, exp_ill);
    end
  endtask

  // Drive inputs away from the edge.
  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    bus.alu_op = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // Drive, let one rising edge capture, then check just after it.
  task automatic apply(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [3:0] exp_ctl, input logic exp_ill);
    drive(op, f3, f7);
    @(posedge clk);
    #1;
    check(tag, exp_ctl, exp_ill);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset with SRA inputs present: outputs cleared before any edge.
    bus.alu_op = 2'b10;
    bus.funct3 = 3'b101;
    bus.funct7 = 7'b0100000;
    reset = 1'b1;
    #1;
    check("reset_immediate", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_sra", 4'b0111, 1'b0);

    // Load/store
    apply("ls_plain",    2'b00, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    apply("ls_ignored",  2'b00, 3'b111, 7'b1111111, 4'b0000, 1'b0);

    // Branch
    apply("beq",   2'b01, 3'b000, 7'b0000000, 4'b0001, 1'b0);
    apply("bne",   2'b01, 3'b001, 7'b1111111, 4'b0001, 1'b0);
    apply("blt",   2'b01, 3'b100, 7'b0000000, 4'b1000, 1'b0);
    apply("bge",   2'b01, 3'b101, 7'b0100000, 4'b1000, 1'b0);
    apply("bltu",  2'b01, 3'b110, 7'b0000000, 4'b1001, 1'b0);
    apply("bgeu",  2'b01, 3'b111, 7'b0000000, 4'b1001, 1'b0);
    apply("br_010", 2'b01, 3'b010, 7'b0000000, 4'b0001, 1'b1);
    apply("br_011", 2'b01, 3'b011, 7'b0000000, 4'b0001, 1'b1);

    // R-type
    apply("r_add",  2'b10, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    apply("r_sub",  2'b10, 3'b000, 7'b0100000, 4'b0001, 1'b0);
    apply("r_and",  2'b10, 3'b111, 7'b0000000, 4'b0010, 1'b0);
    apply("r_or",   2'b10, 3'b110, 7'b0000000, 4'b0011, 1'b0);
    apply("r_xor",  2'b10, 3'b100, 7'b0000000, 4'b0100, 1'b0);
    apply("r_sll",  2'b10, 3'b001, 7'b0000000, 4'b0101, 1'b0);
    apply("r_srl",  2'b10, 3'b101, 7'b0000000, 4'b0110, 1'b0);
    apply("r_sra",  2'b10, 3'b101, 7'b0100000, 4'b0111, 1'b0);
    apply("r_slt",  2'b10, 3'b010, 7'b0000000, 4'b1000, 1'b0);
    apply("r_sltu", 2'b10, 3'b011, 7'b0000000, 4'b1001, 1'b0);
    apply("r_alt_and", 2'b10, 3'b111, 7'b0100000, 4'b0000, 1'b1);
    apply("r_bad_f7",  2'b10, 3'b101, 7'b0000001, 4'b0000, 1'b1);

    // I-type
    apply("addi",      2'b11, 3'b000, 7'b0000000, 4'b0000, 1'b0);
    apply("addi_imm",  2'b11, 3'b000, 7'b1111111, 4'b0000, 1'b0);
    apply("andi",      2'b11, 3'b111, 7'b1010101, 4'b0010, 1'b0);
    apply("ori",       2'b11, 3'b110, 7'b0000000, 4'b0011, 1'b0);
    apply("xori",      2'b11, 3'b100, 7'b0100000, 4'b0100, 1'b0);
    apply("slti",      2'b11, 3'b010, 7'b0000000, 4'b1000, 1'b0);
    apply("sltiu",     2'b11, 3'b011, 7'b1111111, 4'b1001, 1'b0);
    apply("slli",      2'b11, 3'b001, 7'b0000000, 4'b0101, 1'b0);
    apply("slli_bad",  2'b11, 3'b001, 7'b0100000, 4'b0101, 1'b1);
    apply("srli",      2'b11, 3'b101, 7'b0000000, 4'b0110, 1'b0);
    apply("srai",      2'b11, 3'b101, 7'b0100000, 4'b0111, 1'b0);
    apply("srli_bad",  2'b11, 3'b101, 7'b0000010, 4'b0110, 1'b1);

    // Latency: output holds until the next rising edge, then tracks back-to-back changes.
    apply("lat_base", 2'b10, 3'b111, 7'b0000000, 4'b0010, 1'b0);
    @(posedge clk);
    #1;
    bus.alu_op = 2'b10;
    bus.funct3 = 3'b011;
    bus.funct7 = 7'b0000000;
    #1;
    check("lat_hold", 4'b0010, 1'b0);
    @(posedge clk);
    #1;
    check("lat_update", 4'b1001, 1'b0);
    bus.alu_op = 2'b01;
    bus.funct3 = 3'b010;
    bus.funct7 = 7'b0000000;
    #1;
    check("lat_hold2", 4'b1001, 1'b0);
    @(posedge clk);
    #1;
    check("lat_b2b_1", 4'b0001, 1'b1);
    bus.alu_op = 2'b11;
    bus.funct3 = 3'b101;
    bus.funct7 = 7'b0100000;
    @(posedge clk);
    #1;
    check("lat_b2b_2", 4'b0111, 1'b0);

    // Mid-stream reset clears without an edge; first edge after release captures inputs.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_reset", 4'b0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.alu_op = 2'b10;
    bus.funct3 = 3'b100;
    bus.funct7 = 7'b0000000;
    @(posedge clk);
    #1;
    check("after_mid_reset", 4'b0100, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
